bsg_trace_loader: RTL and testbench

Upstream feeder for `bsg_trace_replay`. It accepts trace entries over a valid/ready load channel and stores them in an internal register-file memory. It then serves them to the replay engine through an asynchronous-read ROM port and raises `loaded_o` to enable replay once a terminating entry arrives. Traces can therefore be loaded at run time, for example from a host link or a DPI shim, instead of from a compiled-in ROM.

---
 rtl/bsg_trace_loader.sv | 87 ++++++++
 tb/tb_bsg_trace_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_trace_loader.sv
// Run-time trace loader feeding bsg_trace_replay: valid/ready load channel into a register file, masked async-read ROM port.
// Optional BSG_TRACE_LOADER_OPCHECK_EN flags accepted entries whose op exceeds 4'd6 via error_o.
module bsg_trace_loader #(
  parameter int payload_width_p  = 80,
  parameter int rom_addr_width_p = 6
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          v_i,
  input  logic [payload_width_p+4-1:0]  data_i,
  output logic                          ready_o,
  input  logic [rom_addr_width_p-1:0]   rom_addr_i,
  output logic [payload_width_p+4-1:0]  rom_data_o,
  output logic                          loaded_o,
  output logic [rom_addr_width_p:0]     count_o,
  output logic                          error_o
);
  localparam int els_lp   = 2**rom_addr_width_p;
  localparam int width_lp = payload_width_p + 4;
  localparam int cnt_w_lp = rom_addr_width_p + 1;

  typedef enum logic {LOAD, LOADED} state_e;

  state_e                state_q, state_d;
  logic [cnt_w_lp-1:0]   count_q, count_d;
  logic                  error_q, error_d;
  logic [width_lp-1:0]   mem_q [els_lp];

  logic                  accept;
  logic [3:0]            op;
  logic                  term;
  logic [cnt_w_lp-1:0]   count_plus;
  logic                  full_after;

  assign accept     = v_i & (state_q == LOAD);
  assign op         = data_i[width_lp-1 -: 4];
  assign term       = (op == 4'd3) | (op == 4'd4);
  assign count_plus = count_q + cnt_w_lp'(1);
  assign full_after = (count_plus == cnt_w_lp'(els_lp));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    error_d = error_q;
    if (accept) begin
      count_d = count_plus;
      if (term | full_after) state_d = LOADED;
      // Filling the last slot without a terminator means the trace was truncated.
      if (full_after & ~term) error_d = 1'b1;
`ifdef BSG_TRACE_LOADER_OPCHECK_EN
      if (op > 4'd6) error_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= LOAD;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Storage is never cleared; stale contents stay hidden behind count_q.
  always_ff @(posedge clk_i) begin
    if (accept & ~reset_i) mem_q[count_q[rom_addr_width_p-1:0]] <= data_i;
  end

  assign rom_data_o = ({1'b0, rom_addr_i} < count_q) ? mem_q[rom_addr_i]
                                                     : {4'd3, {payload_width_p{1'b0}}};
  assign ready_o    = (state_q == LOAD);
  assign loaded_o   = (state_q == LOADED);
  assign count_o    = count_q;
  assign error_o    = error_q;

`ifdef BSG_TRACE_LOADER_OPCHECK_EN
  always @(negedge clk_i) begin
    if (accept && !reset_i && op > 4'd6)
      $display("bsg_trace_loader: illegal op %0d at slot %0d", op, count_q);
  end
`endif

endmodule

// File: tb/tb_bsg_trace_loader.sv
// Bench for bsg_trace_loader: a default-size instance and a 4-deep instance for the full-memory cases.
module tb_bsg_trace_loader;
  localparam int PW = 80;
  localparam int W  = PW + 4;
`ifdef BSG_TRACE_LOADER_OPCHECK_EN
  localparam logic OPC_EXP = 1'b1;
`else
  localparam logic OPC_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a, v_a, rdy_a, loaded_a, err_a;
  logic [W-1:0] d_a, rd_a;
  logic [5:0]   addr_a;
  logic [6:0]   cnt_a;

  logic         rst_b, v_b, rdy_b, loaded_b, err_b;
  logic [W-1:0] d_b, rd_b;
  logic [1:0]   addr_b;
  logic [2:0]   cnt_b;

  bsg_trace_loader #(.payload_width_p(PW), .rom_addr_width_p(6)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .v_i(v_a), .data_i(d_a), .ready_o(rdy_a),
    .rom_addr_i(addr_a), .rom_data_o(rd_a), .loaded_o(loaded_a),
    .count_o(cnt_a), .error_o(err_a));

  bsg_trace_loader #(.payload_width_p(PW), .rom_addr_width_p(2)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .v_i(v_b), .data_i(d_b), .ready_o(rdy_b),
    .rom_addr_i(addr_b), .rom_data_o(rd_b), .loaded_o(loaded_b),
    .count_o(cnt_b), .error_o(err_b));

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    int           cnt;
    logic         loaded;
    logic         rdy;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  vec_t sb[$];

  function automatic logic [W-1:0] ent(input logic [3:0] op, input logic [PW-1:0] pl);
    return {op, pl};
  endfunction

  logic [W-1:0] done_e;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive each table row for one cycle; expectations ride a scoreboard until the edge lands.
  task automatic run_tbl(input string nm);
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      v_a = tbl[i].v;
      d_a = tbl[i].d;
      sb.push_back(tbl[i]);
      step();
      e = sb.pop_front();
      chk($sformatf("%s[%0d].count", nm, i), W'(cnt_a), W'(e.cnt));
      chk($sformatf("%s[%0d].loaded", nm, i), W'(loaded_a), W'(e.loaded));
      chk($sformatf("%s[%0d].ready", nm, i), W'(rdy_a), W'(e.rdy));
    end
    v_a = 1'b0;
    tbl.delete();
  endtask

  task automatic rd_chk_a(input string nm, input logic [5:0] a, input logic [W-1:0] exp);
    addr_a = a;
    #1;
    chk(nm, rd_a, exp);
  endtask

  task automatic rd_chk_b(input string nm, input logic [1:0] a, input logic [W-1:0] exp);
    addr_b = a;
    #1;
    chk(nm, rd_b, exp);
  endtask

  task automatic reset_a();
    rst_a = 1'b1; v_a = 1'b0;
    step();
    rst_a = 1'b0;
  endtask

  task automatic reset_b();
    rst_b = 1'b1; v_b = 1'b0;
    step();
    rst_b = 1'b0;
  endtask

  initial begin
    done_e = ent(4'd3, '0);
    rst_a = 1'b1; v_a = 1'b0; d_a = '0; addr_a = '0;
    rst_b = 1'b1; v_b = 1'b0; d_b = '0; addr_b = '0;
    step(); step();
    rst_a = 1'b0; rst_b = 1'b0;

    // reset state
    chk("rst.ready", W'(rdy_a), W'(1));
    chk("rst.loaded", W'(loaded_a), W'(0));
    chk("rst.count", W'(cnt_a), W'(0));
    chk("rst.error", W'(err_a), W'(0));
    chk("rst.rd_a0", rd_a, done_e);
    rd_chk_b("rst.rd_b3", 2'd3, done_e);

    // three back-to-back entries; same-cycle read of slot 0 is still masked
    v_a = 1'b1; d_a = ent(4'd1, 80'hA);
    rd_chk_a("wr_same_cycle", 6'd0, done_e);
    tbl.push_back('{1'b1, ent(4'd1, 80'hA), 1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, ent(4'd2, 80'hB), 2, 1'b0, 1'b1});
    tbl.push_back('{1'b1, ent(4'd3, 80'h0), 3, 1'b1, 1'b0});
    tbl.push_back('{1'b1, ent(4'd1, 80'hC), 3, 1'b1, 1'b0});
    run_tbl("load3");
    rd_chk_a("load3.rd0", 6'd0, ent(4'd1, 80'hA));
    rd_chk_a("load3.rd1", 6'd1, ent(4'd2, 80'hB));
    rd_chk_a("load3.rd2", 6'd2, ent(4'd3, 80'h0));
    rd_chk_a("load3.rd5", 6'd5, done_e);
    chk("load3.error", W'(err_a), W'(0));

    // full memory without terminator on the 4-deep instance
    reset_b();
    for (int i = 0; i < 4; i++) begin
      v_b = 1'b1; d_b = ent(4'd1, PW'(i + 16));
      step();
    end
    chk("full.ready", W'(rdy_b), W'(0));
    d_b = ent(4'd1, 80'h99);
    step();
    v_b = 1'b0;
    chk("full.count", W'(cnt_b), W'(4));
    chk("full.loaded", W'(loaded_b), W'(1));
    chk("full.error", W'(err_b), W'(1));
    rd_chk_b("full.rd3", 2'd3, ent(4'd1, 80'd19));
    rd_chk_b("full.rd0", 2'd0, ent(4'd1, 80'd16));

    // full memory where the last entry is a finish terminator
    reset_b();
    chk("full_term.rst_error", W'(err_b), W'(0));
    for (int i = 0; i < 4; i++) begin
      v_b = 1'b1; d_b = ent((i == 3) ? 4'd4 : 4'd1, PW'(i));
      step();
    end
    v_b = 1'b0;
    chk("full_term.count", W'(cnt_b), W'(4));
    chk("full_term.loaded", W'(loaded_b), W'(1));
    chk("full_term.error", W'(err_b), W'(0));

    // reset coincident with the 2nd handshake
    reset_a();
    v_a = 1'b1; d_a = ent(4'd1, 80'h1);
    step();
    chk("rstmid.count1", W'(cnt_a), W'(1));
    rst_a = 1'b1; d_a = ent(4'd1, 80'h2);
    step();
    rst_a = 1'b0; v_a = 1'b0;
    chk("rstmid.count", W'(cnt_a), W'(0));
    chk("rstmid.ready", W'(rdy_a), W'(1));
    rd_chk_a("rstmid.rd0", 6'd0, done_e);

    // valid with idle gaps: only valid cycles count, order preserved
    reset_a();
    tbl.push_back('{1'b1, ent(4'd1, 80'h11), 1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, ent(4'd3, 80'hEE), 1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, ent(4'd4, 80'hEF), 1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, ent(4'd1, 80'h22), 2, 1'b0, 1'b1});
    tbl.push_back('{1'b0, ent(4'd3, 80'h0), 2, 1'b0, 1'b1});
    run_tbl("gap");
    rd_chk_a("gap.rd0", 6'd0, ent(4'd1, 80'h11));
    rd_chk_a("gap.rd1", 6'd1, ent(4'd1, 80'h22));
    rd_chk_a("gap.rd2", 6'd2, done_e);

    // out-of-range opcode
    reset_a();
    v_a = 1'b1; d_a = ent(4'hF, 80'h5A);
    step();
    v_a = 1'b0;
    chk("opc.error", W'(err_a), W'(OPC_EXP));
    chk("opc.loaded", W'(loaded_a), W'(0));
    chk("opc.count", W'(cnt_a), W'(1));
    rd_chk_a("opc.rd0", 6'd0, ent(4'hF, 80'h5A));

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: %0d leftover entries, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
